// File: rtl/psk_symbol_modulator.sv
// BPSK/QPSK symbol modulator: buffers serial bits, forms one symbol per SPS carrier samples,
// and emits saturated modulated samples one cycle after each carrier tick.
module psk_symbol_modulator #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned SPS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] cos_in,
  input  logic [DATA_W-1:0] sin_in,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [DATA_W-1:0] mod_out,
  output logic              mod_valid,
  output logic              sym_start,
  output logic              underrun
);

  localparam int unsigned CntW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int unsigned ExtW = DATA_W + 2;

  typedef enum logic [1:0] {StIdle, StRun, StMute} state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [1:0]        sym_q, sym_d;
  logic [1:0]        buf_q, buf_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CntW-1:0]   sym_cnt_q, sym_cnt_d;
  logic [DATA_W-1:0] mod_out_q;
  logic              mod_valid_q, sym_start_q, underrun_q;

  logic              accept, boundary, enough;
  logic [1:0]        need;

  logic signed [ExtW-1:0] c_ext, s_ext, i_term, q_term, sum, y;
  logic signed [ExtW-1:0] max_v, min_v;
  logic [DATA_W-1:0]      sat_val, sample_val;

  always_comb begin
    bit_ready = (cnt_q < 2'd2);
    accept    = bit_valid && bit_ready;
    boundary  = sample_en && (sym_cnt_q == '0);
    need      = mode ? 2'd2 : 2'd1;
    enough    = (cnt_q >= need);

    state_d = state_q;
    mode_d  = mode_q;
    sym_d   = sym_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;

    if (boundary) begin
      mode_d = mode;
      if (enough) begin
        state_d = StRun;
        sym_d   = mode ? buf_q : {1'b0, buf_q[0]};
        // Pop the oldest bit(s); survivors shift down to slot 0.
        if (mode) begin
          buf_d = 2'b00;
          cnt_d = 2'd0;
        end else begin
          buf_d = {1'b0, buf_q[1]};
          cnt_d = cnt_q - 2'd1;
        end
      end else begin
        state_d = StMute;
      end
    end

    // Append after any pop; accept implies cnt_d <= 1 here.
    if (accept) begin
      buf_d[cnt_d[0]] = bit_in;
      cnt_d           = cnt_d + 2'd1;
    end

    if (sample_en) begin
      sym_cnt_d = (sym_cnt_q == CntW'(SPS - 1)) ? '0 : sym_cnt_q + 1'b1;
    end else begin
      sym_cnt_d = sym_cnt_q;
    end
  end

  // Datapath uses the post-boundary symbol so the boundary sample already carries it.
  always_comb begin
    c_ext  = $signed({{2{cos_in[DATA_W-1]}}, cos_in});
    s_ext  = $signed({{2{sin_in[DATA_W-1]}}, sin_in});
    i_term = sym_d[0] ? c_ext : -c_ext;
    q_term = sym_d[1] ? s_ext : -s_ext;
    sum    = i_term + q_term;
    max_v  = $signed({3'b000, {(DATA_W-1){1'b1}}});
    min_v  = $signed({3'b111, {(DATA_W-1){1'b0}}});

    if (mode_d) begin
      y = sum >>> 1;
    end else begin
      y = sym_d[0] ? s_ext : -s_ext;
    end

    if (y > max_v) begin
      sat_val = max_v[DATA_W-1:0];
    end else if (y < min_v) begin
      sat_val = min_v[DATA_W-1:0];
    end else begin
      sat_val = y[DATA_W-1:0];
    end

    sample_val = (state_d == StRun) ? sat_val : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      sym_q       <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      sym_cnt_q   <= '0;
      mod_out_q   <= '0;
      mod_valid_q <= 1'b0;
      sym_start_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sym_q       <= sym_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      mod_valid_q <= sample_en;
      sym_start_q <= boundary;
      underrun_q  <= boundary && !enough;
      if (sample_en) begin
        mod_out_q <= sample_val;
      end
    end
  end

  assign mod_out   = mod_out_q;
  assign mod_valid = mod_valid_q;
  assign sym_start = sym_start_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_psk_symbol_modulator.sv
// Scoreboard bench for psk_symbol_modulator at DATA_W=12, SPS=4.
module tb_psk_symbol_modulator;

  localparam int DW  = 12;
  localparam int SPS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode, sample_en, bit_in, bit_valid;
  logic [DW-1:0] cos_in, sin_in;
  logic          bit_ready, mod_valid, sym_start, underrun;
  logic [DW-1:0] mod_out;

  psk_symbol_modulator #(.DATA_W(DW), .SPS(SPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sample_en (sample_en),
    .cos_in    (cos_in),
    .sin_in    (sin_in),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .mod_out   (mod_out),
    .mod_valid (mod_valid),
    .sym_start (sym_start),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    logic          ss;
    logic          ur;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state.
  bit   m_buf[$];
  int   m_cnt;
  int   m_state;  // 0 idle, 1 run, 2 mute
  bit   m_mode, m_i, m_q;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_val(input bit md, input bit i, input bit q,
                                              input logic [DW-1:0] c, input logic [DW-1:0] s);
    int ci, si, y;
    ci = $signed(c);
    si = $signed(s);
    if (!md) y = i ? si : -si;
    else     y = ((i ? ci : -ci) + (q ? si : -si)) >>> 1;
    if (y > 2047)  y = 2047;
    if (y < -2048) y = -2048;
    return DW'(y);
  endfunction

  task automatic model_reset();
    m_buf.delete();
    exp_q.delete();
    m_cnt   = 0;
    m_state = 0;
    m_mode  = 0;
    m_i     = 0;
    m_q     = 0;
  endtask

  // One clock cycle of stimulus; model applies pop before append, like the block.
  task automatic step(input bit se, input logic [DW-1:0] c, input logic [DW-1:0] s,
                      input bit bv, input bit b);
    exp_t e;
    bit   acc;
    int   need;
    sample_en = se;
    cos_in    = c;
    sin_in    = s;
    bit_valid = bv;
    bit_in    = b;
    check("bit_ready", int'(bit_ready), int'(m_buf.size() < 2));
    acc = bv && (m_buf.size() < 2);
    if (se) begin
      e.ss = (m_cnt == 0);
      e.ur = 1'b0;
      if (m_cnt == 0) begin
        m_mode = mode;
        need   = m_mode ? 2 : 1;
        if (m_buf.size() >= need) begin
          m_i     = m_buf.pop_front();
          m_q     = m_mode ? m_buf.pop_front() : 1'b0;
          m_state = 1;
        end else begin
          m_state = 2;
          e.ur    = 1'b1;
        end
      end
      e.val = (m_state == 1) ? model_val(m_mode, m_i, m_q, c, s) : '0;
      exp_q.push_back(e);
      m_cnt = (m_cnt + 1) % SPS;
    end
    if (acc) m_buf.push_back(b);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic push_bit(input bit b);
    step(1'b0, '0, '0, 1'b1, b);
  endtask

  task automatic symbol(input logic [DW-1:0] c, input logic [DW-1:0] s);
    for (int k = 0; k < SPS; k++) step(1'b1, c, s, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && mod_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("mod_out", int'(mod_out), int'(e.val));
        check("sym_start", int'(sym_start), int'(e.ss));
        check("underrun", int'(underrun), int'(e.ur));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sample_en = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    cos_in    = '0;
    sin_in    = '0;
    model_reset();
    #12;
    check("rst_mod_out", int'(mod_out), 0);
    check("rst_mod_valid", int'(mod_valid), 0);
    check("rst_sym_start", int'(sym_start), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_bit_ready", int'(bit_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // BPSK: +100 symbol then -100 symbol.
    mode = 1'b0;
    push_bit(1'b1);
    push_bit(1'b0);
    symbol(12'd100, 12'd100);
    symbol(12'd100, 12'd100);

    // BPSK saturation of -(-2048).
    push_bit(1'b0);
    symbol(12'h000, 12'h800);

    // QPSK: (1000-600)>>>1, then saturating corner; mode wiggle mid-symbol is ignored.
    mode = 1'b1;
    push_bit(1'b1);
    push_bit(1'b0);
    step(1'b1, 12'd1000, 12'd600, 1'b0, 1'b0);
    step(1'b1, 12'd1000, 12'd600, 1'b0, 1'b0);
    mode = 1'b0;
    step(1'b1, 12'd1000, 12'd600, 1'b0, 1'b0);
    mode = 1'b1;
    step(1'b1, 12'd1000, 12'd600, 1'b0, 1'b0);
    push_bit(1'b0);
    push_bit(1'b0);
    symbol(12'h800, 12'h800);

    // QPSK underrun with a single buffered bit, then recovery.
    push_bit(1'b1);
    symbol(12'd700, 12'd300);
    push_bit(1'b0);
    symbol(12'd700, 12'd300);

    // Back-pressure, then pop and accept in the same boundary cycle.
    mode = 1'b0;
    push_bit(1'b1);
    push_bit(1'b0);
    push_bit(1'b1);
    push_bit(1'b1);
    step(1'b1, 12'd0, 12'd321, 1'b1, 1'b1);
    for (int k = 1; k < SPS; k++) step(1'b1, 12'd0, 12'd321, 1'b0, 1'b0);
    step(1'b1, 12'd0, 12'd321, 1'b1, 1'b1);
    for (int k = 1; k < SPS; k++) step(1'b1, 12'd0, 12'd321, 1'b0, 1'b0);
    symbol(12'd0, 12'd321);
    symbol(12'd0, 12'd321);
    step(1'b0, '0, '0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a RUN symbol.
    push_bit(1'b1);
    push_bit(1'b1);
    step(1'b1, 12'd0, 12'd55, 1'b0, 1'b0);
    step(1'b1, 12'd0, 12'd55, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_mod_out", int'(mod_out), 0);
    check("arst_mod_valid", int'(mod_valid), 0);
    check("arst_bit_ready", int'(bit_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_bit(1'b0);
    symbol(12'd0, 12'd77);

    // Random symbols, sometimes under-supplied.
    for (int n = 0; n < 24; n++) begin
      mode = 1'($urandom_range(0, 1));
      for (int k = $urandom_range(0, 2); k > 0; k--) push_bit(1'($urandom_range(0, 1)));
      for (int k = 0; k < SPS; k++)
        step(1'b1, DW'($urandom), DW'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)));
    end

    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
